// File: rtl/disp_chan_sched.sv
// rtl/disp_chan_sched.sv - channel select / capture-strobe scheduler for the 8-channel display mux
// Optional pause input enabled by defining DISP_SCHED_PAUSE_EN.
module disp_chan_sched #(
    parameter logic [31:0] DWELL = 32'd50_000_000,
    parameter logic [3:0]  BLANK = 4'd8
) (
    input  logic       clk,
    input  logic       rst,
`ifdef DISP_SCHED_PAUSE_EN
    input  logic       pause,
`endif
    input  logic       auto_mode,
    input  logic [2:0] sw_sel,
    input  logic [7:0] ch_en,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       cpu_req,
    output logic [2:0] Test,
    output logic       EN,
    output logic       cpu_ack,
    output logic       blank_out,
    output logic       dwell_tick
);

    typedef enum logic {S_SHOW, S_BLANK} state_t;

    state_t      state;
    logic [31:0] dwell_cnt;
    logic [3:0]  blank_cnt;
    logic        armed;

    logic [7:0]  em;
    logic [2:0]  nxt_ch;
    logic [2:0]  prv_ch;
    logic [2:0]  tgt;
    logic        paused;
    logic        expire;
    logic        change;
    logic        grant;

    // Nearest set bit walking away from cur; returns cur when no other bit is set.
    function automatic logic [2:0] scan_mask(input logic [2:0] cur, input logic [7:0] m,
                                             input logic up);
        logic [2:0] r;
        logic [2:0] c;
        r = cur;
        for (int i = 7; i >= 1; i--) begin
            c = up ? cur + 3'(i) : cur - 3'(i);
            if (m[c]) r = c;
        end
        return r;
    endfunction

`ifdef DISP_SCHED_PAUSE_EN
    assign paused = auto_mode & pause;
`else
    assign paused = 1'b0;
`endif

    always_comb begin
        em     = (ch_en == 8'h00) ? 8'h01 : ch_en;
        nxt_ch = scan_mask(Test, em, 1'b1);
        prv_ch = scan_mask(Test, em, 1'b0);
        expire = auto_mode && !paused && (dwell_cnt == DWELL - 32'd1);
        tgt    = Test;
        if (!auto_mode)
            tgt = sw_sel;
        else if (btn_next && !btn_prev)
            tgt = nxt_ch;
        else if (btn_prev && !btn_next)
            tgt = prv_ch;
        else if (!em[Test] || expire)
            tgt = nxt_ch;
        change = (state == S_SHOW) && (tgt != Test);
        grant  = (state == S_SHOW) && cpu_req && armed;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_SHOW;
            Test       <= 3'd0;
            EN         <= 1'b0;
            cpu_ack    <= 1'b0;
            blank_out  <= 1'b0;
            dwell_tick <= 1'b0;
            dwell_cnt  <= 32'd0;
            blank_cnt  <= 4'd0;
            armed      <= 1'b1;
        end else begin
            EN         <= grant;
            cpu_ack    <= grant;
            dwell_tick <= (state == S_SHOW) && expire;
            if (!cpu_req)
                armed <= 1'b1;
            else if (grant)
                armed <= 1'b0;
            case (state)
                S_SHOW: begin
                    if (change) begin
                        Test      <= tgt;
                        state     <= S_BLANK;
                        blank_out <= 1'b1;
                        blank_cnt <= BLANK - 4'd1;
                        dwell_cnt <= 32'd0;
                    end else if (!auto_mode || expire) begin
                        dwell_cnt <= 32'd0;
                    end else if (!paused) begin
                        dwell_cnt <= dwell_cnt + 32'd1;
                    end
                end
                S_BLANK: begin
                    if (blank_cnt == 4'd0) begin
                        state     <= S_SHOW;
                        blank_out <= 1'b0;
                    end else begin
                        blank_cnt <= blank_cnt - 4'd1;
                    end
                end
                default: state <= S_SHOW;
            endcase
        end
    end

endmodule

// File: tb/tb_disp_chan_sched.sv
// tb/tb_disp_chan_sched.sv - randomized bench for disp_chan_sched against a behavioural model
module tb_disp_chan_sched;

    localparam int DW = 4;
    localparam int BL = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       auto_mode = 1'b0;
    logic [2:0] sw_sel = 3'd0;
    logic [7:0] ch_en = 8'h00;
    logic       btn_next = 1'b0;
    logic       btn_prev = 1'b0;
    logic       cpu_req = 1'b0;
`ifdef DISP_SCHED_PAUSE_EN
    logic       pause = 1'b0;
`endif
    logic [2:0] Test;
    logic       EN;
    logic       cpu_ack;
    logic       blank_out;
    logic       dwell_tick;

    int n_chk = 0;
    int n_bad = 0;

    int m_test;
    int m_blank_left;
    int m_dwell;
    bit m_armed;
    bit m_en;
    bit m_tick;

    always #5 clk = ~clk;

    disp_chan_sched #(.DWELL(32'd4), .BLANK(4'd2)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef DISP_SCHED_PAUSE_EN
        .pause      (pause),
`endif
        .auto_mode  (auto_mode),
        .sw_sel     (sw_sel),
        .ch_en      (ch_en),
        .btn_next   (btn_next),
        .btn_prev   (btn_prev),
        .cpu_req    (cpu_req),
        .Test       (Test),
        .EN         (EN),
        .cpu_ack    (cpu_ack),
        .blank_out  (blank_out),
        .dwell_tick (dwell_tick)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int scan(input int cur, input logic [7:0] m, input int dir);
        for (int k = 1; k < 8; k++) begin
            int idx;
            idx = (cur + dir * k + 16) % 8;
            if (m[idx]) return idx;
        end
        return cur;
    endfunction

    task automatic model_reset();
        m_test = 0;
        m_blank_left = 0;
        m_dwell = 0;
        m_armed = 1'b1;
        m_en = 1'b0;
        m_tick = 1'b0;
    endtask

    task automatic model_step();
        logic [7:0] em;
        int  tgt;
        bit  frozen;
        frozen = 1'b0;
`ifdef DISP_SCHED_PAUSE_EN
        frozen = auto_mode && pause;
`endif
        m_en = 1'b0;
        m_tick = 1'b0;
        em = (ch_en == 8'h00) ? 8'h01 : ch_en;
        if (m_blank_left > 0) begin
            m_blank_left--;
        end else begin
            m_en = cpu_req && m_armed;
            tgt = m_test;
            if (!auto_mode) begin
                tgt = sw_sel;
                m_dwell = 0;
            end else begin
                m_tick = !frozen && (m_dwell == DW - 1);
                if (btn_next && !btn_prev) tgt = scan(m_test, em, 1);
                else if (btn_prev && !btn_next) tgt = scan(m_test, em, -1);
                else if (!em[m_test] || m_tick) tgt = scan(m_test, em, 1);
                if (m_tick) m_dwell = 0;
                else if (!frozen) m_dwell++;
            end
            if (tgt != m_test) begin
                m_test = tgt;
                m_blank_left = BL;
                m_dwell = 0;
            end
        end
        if (!cpu_req) m_armed = 1'b1;
        else if (m_en) m_armed = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        chk("Test", 32'(Test), 32'(m_test));
        chk("EN", 32'(EN), 32'(m_en));
        chk("cpu_ack", 32'(cpu_ack), 32'(m_en));
        chk("blank_out", 32'(blank_out), 32'(m_blank_left > 0));
        chk("dwell_tick", 32'(dwell_tick), 32'(m_tick));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_Test", 32'(Test), 32'd0);
        chk("rst_EN", 32'(EN), 32'd0);
        chk("rst_blank", 32'(blank_out), 32'd0);
        chk("rst_tick", 32'(dwell_tick), 32'd0);
        rst = 1'b0;

        steps(2);
        sw_sel = 3'd5;
        steps(5);
        sw_sel = 3'd3;
        step();
        chk("pre_rst_blank", 32'(blank_out), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_Test", 32'(Test), 32'd0);
        chk("async_blank", 32'(blank_out), 32'd0);
        chk("async_EN", 32'(EN), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sw_sel = 3'd0;
        model_reset();

        ch_en = 8'b1000_0101;
        auto_mode = 1'b1;
        steps(20);
        btn_prev = 1'b1;
        step();
        btn_prev = 1'b0;
        steps(4);
        btn_next = 1'b1;
        btn_prev = 1'b1;
        step();
        btn_next = 1'b0;
        btn_prev = 1'b0;
        steps(3);
        ch_en = 8'h00;
        steps(12);
        ch_en = 8'b1000_0101;
        cpu_req = 1'b1;
        steps(15);
        cpu_req = 1'b0;
        step();
        cpu_req = 1'b1;
        steps(5);
        cpu_req = 1'b0;

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 59) == 0) auto_mode = ~auto_mode;
            if ($urandom_range(0, 39) == 0)
                ch_en = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 7) == 0) sw_sel = 3'($urandom);
            btn_next = ($urandom_range(0, 9) == 0);
            btn_prev = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 4) == 0) cpu_req = ~cpu_req;
`ifdef DISP_SCHED_PAUSE_EN
            if ($urandom_range(0, 11) == 0) pause = ~pause;
`endif
            step();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/disp_chan_sched.md
Name: disp_chan_sched

Overview:
- Scheduler for the 8-channel 32-bit display multiplexer.
- Generates the 3-bit channel select (Test) and the channel-0 capture strobe (EN) that the multiplexer consumes.
- Supports manual selection from switches, and automatic rotation through a mask of enabled channels with a per-channel dwell time.
- Inserts a blanking window on every channel change and arbitrates CPU channel-0 update requests against that window.

Parameters:
DWELL, 32'd50_000_000, clock cycles each channel is shown in AUTO mode (minimum 2)
BLANK, 4'd8, clock cycles blank_out is held after any channel change (minimum 1)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
auto_mode  in  1  1 = AUTO rotation, 0 = MANUAL
sw_sel  in  3  manual channel select
ch_en  in  8  AUTO-mode channel enable mask; bit n enables channel n
btn_next  in  1  single-cycle pulse, already debounced: advance one enabled channel
btn_prev  in  1  single-cycle pulse, already debounced: step back one enabled channel
cpu_req  in  1  level request to load channel-0 data
Test  out  3  registered channel select to the multiplexer
EN  out  1  single-cycle capture strobe for channel-0 latches
cpu_ack  out  1  single-cycle grant, coincident with EN
blank_out  out  1  high during the blanking window
dwell_tick  out  1  single-cycle pulse when the AUTO dwell timer expires

Behaviour:
- Reset (asynchronous, any state): Test=0, EN=0, cpu_ack=0, blank_out=0, dwell_tick=0, dwell counter=0, blank counter=0, grant-armed flag=1, state=SHOW.
- States:
  - SHOW: hold the current channel.
  - BLANK: count down BLANK cycles, then return to SHOW.
- Channel change rule:
  - On a change, Test updates on the same clock edge that enters BLANK.
  - blank_out is high for exactly BLANK cycles starting that edge.
  - The dwell counter clears on that edge.
- Effective mask: em = (ch_en==0) ? 8'h01 : ch_en.
- Next / previous channel: first set bit of em searching upward (next) or downward (prev) from Test, modulo 8, wrapping 7->0 and 0->7. If the only set bit is Test itself, no change and no BLANK.
- MANUAL mode, evaluated in SHOW only:
  - If sw_sel != Test, change to sw_sel. ch_en is ignored.
  - btn_next/btn_prev are ignored.
  - Dwell counter is held at 0.
- AUTO mode, evaluated in SHOW only:
  - Dwell counter increments each cycle.
  - When it reaches DWELL-1: dwell_tick=1 for one cycle, change to next enabled channel.
  - btn_next: immediate change to next enabled channel. btn_prev: immediate change to previous enabled channel.
  - Priority: btn_next and btn_prev together means both are ignored. A button in the same cycle as dwell expiry takes priority over expiry, and dwell_tick still pulses.
  - If Test is not set in em (mask changed, or entry from MANUAL), change to next enabled channel on the first SHOW cycle.
- Events during BLANK:
  - Buttons, sw_sel changes and mode changes arriving during BLANK are dropped.
  - Those conditions are re-evaluated in the first SHOW cycle, so level conditions still take effect.
  - blank counter restarts only on a new change.
- CPU grant:
  - A grant is pending when cpu_req=1 and the armed flag is set.
  - Grant in the first SHOW cycle with a pending request: EN=1 and cpu_ack=1 for exactly one cycle; armed flag cleared.
  - Armed flag re-sets after cpu_req has been sampled 0 for at least one cycle.
  - A grant and a channel change may occur in the same cycle; EN is independent of Test.
- Latency:
  - sw_sel change to Test update: 1 cycle.
  - cpu_req rising in SHOW to cpu_ack: 1 cycle.
- Widths: dwell counter 32 bits, blank counter 4 bits, unsigned; no overflow is possible because DWELL >= 2.

Optional Feature:
- Macro: DISP_SCHED_PAUSE_EN.
- Defined:
  - Adds input port pause (1 bit).
  - While pause=1 in AUTO mode, the dwell counter freezes and no dwell_tick occurs.
  - Buttons still change the channel.
  - On release, counting resumes from the frozen value.
- Undefined: no pause port; behaviour exactly as above.

Test Plan (DWELL=4, BLANK=2, ch_en=8'b1000_0101):
- Reset asserted asynchronously mid-BLANK with Test=3 -> Test=0, blank_out=0, EN=0 immediately, before the next clock edge.
- MANUAL, sw_sel 0->5 -> Test=5 one cycle later; blank_out high 2 cycles; no dwell_tick.
- AUTO from Test=0 -> Test sequence 0,2,7,0; each change preceded by a dwell_tick; dwell_tick period 6 cycles (4 dwell + 2 blank).
- AUTO, Test=0, btn_prev pulse -> Test=7; btn_next and btn_prev in the same cycle -> no change. ch_en=0 -> Test goes to 0 and stays.
- cpu_req held high across a channel change -> exactly one EN/cpu_ack pulse, in the first SHOW cycle after BLANK. Drop cpu_req one cycle, raise again -> second pulse.
- Pause feature (macro defined), pause=1 at dwell count 2 for 10 cycles -> no dwell_tick during pause; tick occurs 2 cycles after release.
